// File: rtl/psum_requant_packer.sv
`timescale 1ns/1ps
// psum_requant_packer
// Requantizes int32 partial-sum beats from the systolic tile to int8 using a
// per-channel {relu, shift, mult, bias} table, packs 8 lanes per beat and
// buffers the results in an output FIFO with valid/ready handshakes.
//
// Ports
//   clk, rst                      rising-edge clock, synchronous active-high reset
//   start, out_channel, out_pixels layer start pulse and layer shape (C, P)
//   param_wr_en/addr/data          per-channel parameter table write (IDLE only)
//   psum_valid/psum_data/psum_ready partial-sum input stream (8 x int32)
//   m_valid/m_ready/m_data/m_last  packed output stream (8 x int8)
//   layer_done                     one-cycle pulse once the layer has drained
//   cfg_err                        sticky illegal-configuration flag
module psum_requant_packer #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned MAX_CH     = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [15:0]  out_channel,
  input  logic [31:0]  out_pixels,
  input  logic         param_wr_en,
  input  logic [5:0]   param_wr_addr,
  input  logic [53:0]  param_wr_data,
  input  logic         psum_valid,
  input  logic [255:0] psum_data,
  output logic         psum_ready,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [63:0]  m_data,
  output logic         m_last,
  output logic         layer_done,
  output logic         cfg_err
);

  localparam int unsigned LANES = 8;
  localparam int unsigned PRM_W = 54;
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CW    = AW + 1;
  localparam int unsigned G_MAX = (MAX_CH + 7) / 8;
  localparam int unsigned GW    = (G_MAX > 1) ? $clog2(G_MAX) : 1;
  localparam int unsigned CHW   = GW + 3;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t r_state, w_state_nxt;

  logic [PRM_W-1:0] r_tab [MAX_CH];

  logic [15:0]   r_cfg_c;
  logic [31:0]   r_plast;
  logic [GW-1:0] r_glast;
  logic [GW-1:0] r_grp;
  logic [31:0]   r_pix;
  logic          r_cfg_err;
  logic          r_layer_done;

  // Pipeline stage registers
  logic                r1_v, r2_v, r3_v;
  logic signed [32:0]  r1_s1    [LANES];
  logic signed [15:0]  r1_mult  [LANES];
  logic [4:0]          r1_shift [LANES];
  logic [LANES-1:0]    r1_relu, r1_pad;
  logic                r1_last;
  logic signed [48:0]  r2_s2    [LANES];
  logic [4:0]          r2_shift [LANES];
  logic [LANES-1:0]    r2_relu, r2_pad;
  logic                r2_last;
  logic [63:0]         r3_data;
  logic                r3_last;

  // Output FIFO
  logic [64:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_m_valid;

  logic             w_cfg_ok;
  logic             w_accept;
  logic             w_last_beat;
  logic [CW-1:0]    w_inflight;
  logic             w_drained;
  logic             w_done_nxt;
  logic             w_push, w_pop;
  logic [CW-1:0]    w_count_nxt;
  logic [CHW-1:0]   w_ch  [LANES];
  logic [LANES-1:0] w_pad;
  logic [PRM_W-1:0] w_prm [LANES];

  // Round-half-up arithmetic shift, saturate to int8, optional ReLU, padding mask
  function automatic logic [7:0] f_requant(input logic signed [48:0] s2,
                                           input logic [4:0] sh,
                                           input logic relu,
                                           input logic pad);
    logic signed [49:0] t;
    logic [7:0]         q;
    t = 50'(s2);
    if (sh != 5'd0) t = (t + (50'sd1 <<< (sh - 5'd1))) >>> sh;
    if (t > 50'sd127)       q = 8'h7F;
    else if (t < -50'sd128) q = 8'h80;
    else                    q = t[7:0];
    if (relu && q[7]) q = 8'h00;
    if (pad)          q = 8'h00;
    return q;
  endfunction

  assign w_cfg_ok    = (out_channel != 16'd0) && (out_channel <= 16'(MAX_CH)) &&
                       (out_pixels != 32'd0);
  assign w_accept    = psum_valid && psum_ready;
  assign w_last_beat = (r_grp == r_glast) && (r_pix == r_plast);
  assign w_inflight  = CW'(r1_v) + CW'(r2_v) + CW'(r3_v);
  assign w_drained   = (r_count == '0) && !r1_v && !r2_v && !r3_v;
  // Reserve FIFO room for every beat already in the pipeline so none is dropped
  assign psum_ready  = (r_state == S_RUN) && ((r_count + w_inflight) < CW'(FIFO_DEPTH));

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE:  if (start && w_cfg_ok) w_state_nxt = S_RUN;
      S_RUN:   if (w_accept && w_last_beat) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_drained) begin
                 w_state_nxt = S_IDLE;
                 w_done_nxt  = 1'b1;
               end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Layer config, beat counters and status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cfg_c      <= '0;
      r_plast      <= '0;
      r_glast      <= '0;
      r_grp        <= '0;
      r_pix        <= '0;
      r_cfg_err    <= 1'b0;
      r_layer_done <= 1'b0;
    end else begin
      r_layer_done <= w_done_nxt;
      if (start && (r_state == S_IDLE)) begin
        if (w_cfg_ok) begin
          r_cfg_err <= 1'b0;
          r_cfg_c   <= out_channel;
          r_plast   <= out_pixels - 32'd1;
          r_glast   <= GW'((out_channel - 16'd1) >> 3);
          r_grp     <= '0;
          r_pix     <= '0;
        end else begin
          r_cfg_err <= 1'b1;
        end
      end else if (w_accept) begin
        if (r_grp == r_glast) begin
          r_grp <= '0;
          r_pix <= r_pix + 32'd1;
        end else begin
          r_grp <= r_grp + GW'(1);
        end
      end
    end
  end

  // Parameter table: not reset, frozen while a layer is active
  always_ff @(posedge clk) begin
    if (param_wr_en && (r_state == S_IDLE)) r_tab[param_wr_addr] <= param_wr_data;
  end

  // Per-lane channel index, padding mask and parameter lookup
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      w_ch[i]  = {r_grp, 3'(i)};
      w_pad[i] = (16'(w_ch[i]) >= r_cfg_c);
      w_prm[i] = w_pad[i] ? '0 : r_tab[w_ch[i]];
    end
  end

  // Pipeline valids
  always_ff @(posedge clk) begin
    if (rst) begin
      r1_v <= 1'b0;
      r2_v <= 1'b0;
      r3_v <= 1'b0;
    end else begin
      r1_v <= w_accept;
      r2_v <= r1_v;
      r3_v <= r2_v;
    end
  end

  // Datapath: bias add, multiply, round/shift/saturate
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      r1_s1[i]    <= 33'($signed(psum_data[32*i +: 32])) + 33'($signed(w_prm[i][31:0]));
      r1_mult[i]  <= w_prm[i][47:32];
      r1_shift[i] <= w_prm[i][52:48];
      r1_relu[i]  <= w_prm[i][53];
      r1_pad[i]   <= w_pad[i];

      r2_s2[i]    <= 49'(r1_s1[i]) * 49'(r1_mult[i]);
      r2_shift[i] <= r1_shift[i];
      r2_relu[i]  <= r1_relu[i];
      r2_pad[i]   <= r1_pad[i];

      r3_data[8*i +: 8] <= f_requant(r2_s2[i], r2_shift[i], r2_relu[i], r2_pad[i]);
    end
    r1_last <= w_last_beat;
    r2_last <= r1_last;
    r3_last <= r2_last;
  end

  assign w_push      = r3_v;
  assign w_pop       = r_m_valid && m_ready;
  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

  // FIFO pointers, occupancy and output valid
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_m_valid <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count   <= w_count_nxt;
      r_m_valid <= (w_count_nxt != '0);
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (!rst && w_push) r_mem[r_wr_ptr] <= {r3_last, r3_data};
  end

  assign m_valid    = r_m_valid;
  assign m_data     = r_mem[r_rd_ptr][63:0];
  assign m_last     = r_m_valid & r_mem[r_rd_ptr][64];
  assign layer_done = r_layer_done;
  assign cfg_err    = r_cfg_err;

endmodule

// File: tb/tb_psum_requant_packer.sv
`timescale 1ns/1ps
// Directed bench for psum_requant_packer: identity/saturation, rounding/ReLU,
// bias, padding and m_last, backpressure, illegal config and mid-layer reset.
module tb_psum_requant_packer;

  logic         clk;
  logic         rst;
  logic         start;
  logic [15:0]  out_channel;
  logic [31:0]  out_pixels;
  logic         param_wr_en;
  logic [5:0]   param_wr_addr;
  logic [53:0]  param_wr_data;
  logic         psum_valid;
  logic [255:0] psum_data;
  logic         psum_ready;
  logic         m_valid;
  logic         m_ready;
  logic [63:0]  m_data;
  logic         m_last;
  logic         layer_done;
  logic         cfg_err;

  int checks;
  int failures;
  int done_cnt;
  int acc_cnt;
  int tx_idx;
  logic [64:0]  rx_q [$];
  logic [255:0] tx_q [$];

  psum_requant_packer dut (
    .clk(clk), .rst(rst), .start(start), .out_channel(out_channel),
    .out_pixels(out_pixels), .param_wr_en(param_wr_en), .param_wr_addr(param_wr_addr),
    .param_wr_data(param_wr_data), .psum_valid(psum_valid), .psum_data(psum_data),
    .psum_ready(psum_ready), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .layer_done(layer_done), .cfg_err(cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observe handshakes mid-cycle, away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      if (m_valid && m_ready) rx_q.push_back({m_last, m_data});
      if (layer_done) done_cnt++;
      if (psum_valid && psum_ready) acc_cnt++;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_param(input int ch, input bit relu, input int sh, input int mult, input int bias);
    param_wr_en   = 1'b1;
    param_wr_addr = 6'(ch);
    param_wr_data = {relu, 5'(sh), 16'(mult), 32'(bias)};
    tick();
    param_wr_en   = 1'b0;
  endtask

  task automatic start_layer(input int c, input int p);
    start       = 1'b1;
    out_channel = 16'(c);
    out_pixels  = 32'(p);
    tick();
    start       = 1'b0;
  endtask

  function automatic logic [255:0] mk_beat(input int v0, input int v1, input int v2, input int v3,
                                           input int v4, input int v5, input int v6, input int v7);
    return {32'(v7), 32'(v6), 32'(v5), 32'(v4), 32'(v3), 32'(v2), 32'(v1), 32'(v0)};
  endfunction

  // Offer queued beats with psum_valid held high for up to max_cyc cycles
  task automatic stream(input int max_cyc);
    logic rdy;
    for (int n = 0; n < max_cyc && tx_idx < tx_q.size(); n++) begin
      psum_valid = 1'b1;
      psum_data  = tx_q[tx_idx];
      rdy        = psum_ready;
      tick();
      if (rdy) tx_idx++;
    end
    psum_valid = 1'b0;
  endtask

  task automatic wait_done(input int target, input int max_cyc);
    for (int n = 0; n < max_cyc && done_cnt < target; n++) tick();
    repeat (5) tick();
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks++; if (psum_ready !== 1'b0) begin failures++; $display("FAIL rst_psum_ready got=%b exp=0", psum_ready); end
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL rst_m_valid got=%b exp=0", m_valid); end
    checks++; if (m_last !== 1'b0) begin failures++; $display("FAIL rst_m_last got=%b exp=0", m_last); end
    checks++; if (layer_done !== 1'b0) begin failures++; $display("FAIL rst_layer_done got=%b exp=0", layer_done); end
    checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL rst_cfg_err got=%b exp=0", cfg_err); end
    rst = 1'b0;
    tick();
    checks++; if (psum_ready !== 1'b0) begin failures++; $display("FAIL idle_psum_ready got=%b exp=0", psum_ready); end
  endtask

  task automatic test_identity();
    for (int c = 0; c < 64; c++) write_param(c, 1'b0, 0, 1, 0);
    rx_q.delete(); done_cnt = 0;
    start_layer(8, 1);
    checks++; if (psum_ready !== 1'b1) begin failures++; $display("FAIL id_ready_run got=%b exp=1", psum_ready); end
    psum_valid = 1'b1;
    psum_data  = mk_beat(100, 200, -300, 0, 127, -128, 5, -5);
    tick();
    psum_valid = 1'b0;
    checks++; if (psum_ready !== 1'b0) begin failures++; $display("FAIL id_ready_drain got=%b exp=0", psum_ready); end
    tick();
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL id_lat1 m_valid got=%b exp=0", m_valid); end
    tick();
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL id_lat2 m_valid got=%b exp=0", m_valid); end
    tick();
    checks++; if (m_valid !== 1'b1) begin failures++; $display("FAIL id_lat3 m_valid got=%b exp=1", m_valid); end
    checks++; if (m_data !== 64'hFB05_807F_0080_7F64) begin failures++; $display("FAIL id_data got=%h exp=fb05807f00807f64", m_data); end
    checks++; if (m_last !== 1'b1) begin failures++; $display("FAIL id_last got=%b exp=1", m_last); end
    wait_done(1, 50);
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL id_done got=%0d exp=1", done_cnt); end
    checks++; if (rx_q.size() !== 1) begin failures++; $display("FAIL id_beats got=%0d exp=1", rx_q.size()); end
  endtask

  task automatic test_rounding_relu();
    write_param(0, 1'b0, 2, 3, 0);
    write_param(1, 1'b0, 2, 3, 0);
    write_param(2, 1'b1, 2, 3, 0);
    write_param(3, 1'b1, 2, 3, 0);
    rx_q.delete(); done_cnt = 0;
    start_layer(8, 1);
    tx_q = {mk_beat(5, -5, -5, 5, 0, 0, 0, 0)}; tx_idx = 0;
    stream(20);
    wait_done(1, 50);
    checks++; if (rx_q.size() !== 1) begin failures++; $display("FAIL rnd_beats got=%0d exp=1", rx_q.size()); end
    if (rx_q.size() >= 1) begin
      checks++; if (rx_q[0][63:0] !== 64'h0000_0000_0400_FC04) begin failures++; $display("FAIL rnd_data got=%h exp=000000000400fc04", rx_q[0][63:0]); end
      checks++; if (rx_q[0][64] !== 1'b1) begin failures++; $display("FAIL rnd_last got=%b exp=1", rx_q[0][64]); end
    end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL rnd_done got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_bias();
    write_param(0, 1'b0, 0, 1, -10);
    write_param(1, 1'b0, 1, -2, 7);
    write_param(2, 1'b0, 1, 1, 0);
    write_param(3, 1'b0, 1, 1, 0);
    write_param(4, 1'b0, 0, 1, 32'h7FFF_FFFF);
    rx_q.delete(); done_cnt = 0;
    start_layer(8, 1);
    tx_q = {mk_beat(4, 10, 3, -3, 32'h7FFF_FFFF, 0, 0, 0)}; tx_idx = 0;
    stream(20);
    wait_done(1, 50);
    checks++; if (rx_q.size() !== 1) begin failures++; $display("FAIL bias_beats got=%0d exp=1", rx_q.size()); end
    if (rx_q.size() >= 1) begin
      checks++; if (rx_q[0][63:0] !== 64'h0000_007F_FF02_EFFA) begin failures++; $display("FAIL bias_data got=%h exp=0000007fff02effa", rx_q[0][63:0]); end
    end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL bias_done got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_padding_last();
    logic [63:0] e;
    for (int c = 0; c < 64; c++) write_param(c, 1'b0, 0, 1, (c >= 35 && c < 40) ? 50 : 0);
    rx_q.delete(); done_cnt = 0;
    start_layer(35, 2);
    tx_q.delete(); tx_idx = 0;
    for (int b = 0; b < 10; b++)
      tx_q.push_back(mk_beat(b*8, b*8+1, b*8+2, b*8+3, b*8+4, b*8+5, b*8+6, b*8+7));
    stream(3);
    start_layer(8, 1);
    stream(100);
    wait_done(1, 100);
    checks++; if (rx_q.size() !== 10) begin failures++; $display("FAIL pad_beats got=%0d exp=10", rx_q.size()); end
    for (int b = 0; b < 10 && b < rx_q.size(); b++) begin
      for (int i = 0; i < 8; i++) e[8*i +: 8] = ((b % 5) == 4 && i >= 3) ? 8'h00 : 8'(b*8 + i);
      checks++; if (rx_q[b][63:0] !== e) begin failures++; $display("FAIL pad_data beat=%0d got=%h exp=%h", b, rx_q[b][63:0], e); end
      checks++; if (rx_q[b][64] !== (b == 9)) begin failures++; $display("FAIL pad_last beat=%0d got=%b exp=%b", b, rx_q[b][64], (b == 9)); end
    end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL pad_done got=%0d exp=1", done_cnt); end
    checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL pad_cfg_err got=%b exp=0", cfg_err); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] e;
    rx_q.delete(); done_cnt = 0; acc_cnt = 0;
    m_ready = 1'b0;
    start_layer(16, 10);
    tx_q.delete(); tx_idx = 0;
    for (int b = 0; b < 20; b++) tx_q.push_back(mk_beat(b, 1, 2, 3, 4, 5, 6, 7));
    stream(20);
    checks++; if (acc_cnt !== 8) begin failures++; $display("FAIL bp_accepted got=%0d exp=8", acc_cnt); end
    checks++; if (psum_ready !== 1'b0) begin failures++; $display("FAIL bp_ready got=%b exp=0", psum_ready); end
    checks++; if (m_valid !== 1'b1) begin failures++; $display("FAIL bp_m_valid got=%b exp=1", m_valid); end
    checks++; if (m_data !== 64'h0706_0504_0302_0100) begin failures++; $display("FAIL bp_hold_data got=%h exp=0706050403020100", m_data); end
    checks++; if (m_last !== 1'b0) begin failures++; $display("FAIL bp_hold_last got=%b exp=0", m_last); end
    m_ready = 1'b1;
    stream(300);
    wait_done(1, 100);
    checks++; if (rx_q.size() !== 20) begin failures++; $display("FAIL bp_beats got=%0d exp=20", rx_q.size()); end
    for (int b = 0; b < 20 && b < rx_q.size(); b++) begin
      e = {8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'(b)};
      checks++; if (rx_q[b] !== {(b == 19), e}) begin failures++; $display("FAIL bp_order beat=%0d got=%h exp=%h", b, rx_q[b], {(b == 19), e}); end
    end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL bp_done got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_illegal_and_reset();
    int n_before;
    done_cnt = 0;
    start_layer(0, 4);
    checks++; if (cfg_err !== 1'b1) begin failures++; $display("FAIL ill_c0_err got=%b exp=1", cfg_err); end
    checks++; if (psum_ready !== 1'b0) begin failures++; $display("FAIL ill_c0_idle got=%b exp=0", psum_ready); end
    start_layer(65, 1);
    checks++; if (cfg_err !== 1'b1) begin failures++; $display("FAIL ill_c65_err got=%b exp=1", cfg_err); end
    start_layer(8, 0);
    checks++; if (cfg_err !== 1'b1) begin failures++; $display("FAIL ill_p0_err got=%b exp=1", cfg_err); end
    checks++; if (psum_ready !== 1'b0) begin failures++; $display("FAIL ill_p0_idle got=%b exp=0", psum_ready); end
    start_layer(8, 4);
    checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL ill_clear_err got=%b exp=0", cfg_err); end
    checks++; if (psum_ready !== 1'b1) begin failures++; $display("FAIL ill_run_ready got=%b exp=1", psum_ready); end
    tx_q = {mk_beat(1, 0, 0, 0, 0, 0, 0, 0), mk_beat(2, 0, 0, 0, 0, 0, 0, 0)}; tx_idx = 0;
    stream(2);
    write_param(0, 1'b0, 0, 1, 100);
    for (int n = 0; n < 10 && !m_valid; n++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL abort_m_valid got=%b exp=0", m_valid); end
    checks++; if (psum_ready !== 1'b0) begin failures++; $display("FAIL abort_ready got=%b exp=0", psum_ready); end
    n_before = rx_q.size();
    repeat (10) tick();
    checks++; if (rx_q.size() !== n_before) begin failures++; $display("FAIL abort_no_output got=%0d exp=%0d", rx_q.size(), n_before); end
    checks++; if (done_cnt !== 0) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", done_cnt); end
    rx_q.delete();
    start_layer(8, 1);
    tx_q = {mk_beat(100, 200, -300, 0, 127, -128, 5, -5)}; tx_idx = 0;
    stream(20);
    wait_done(1, 50);
    checks++; if (rx_q.size() !== 1) begin failures++; $display("FAIL fresh_beats got=%0d exp=1", rx_q.size()); end
    if (rx_q.size() >= 1) begin
      checks++; if (rx_q[0] !== {1'b1, 64'hFB05_807F_0080_7F64}) begin failures++; $display("FAIL fresh_data got=%h exp=1fb05807f00807f64", rx_q[0]); end
    end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL fresh_done got=%0d exp=1", done_cnt); end
  endtask

  initial begin
    checks = 0; failures = 0; done_cnt = 0; acc_cnt = 0; tx_idx = 0;
    rst = 1'b1; start = 1'b0; out_channel = '0; out_pixels = '0;
    param_wr_en = 1'b0; param_wr_addr = '0; param_wr_data = '0;
    psum_valid = 1'b0; psum_data = '0; m_ready = 1'b1;
    test_reset();
    test_identity();
    test_rounding_relu();
    test_bias();
    test_padding_last();
    test_back_to_back();
    test_illegal_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/psum_requant_packer.md
PSUM_REQUANT_PACKER -- requirements
Module: psum_requant_packer

Interface
REQ-001 Parameter FIFO_DEPTH, default 8: output FIFO entries, power of two, minimum 4.
REQ-002 Parameter MAX_CH, default 64: per-channel parameter table depth, so the table address is 6 bits.
REQ-003 clk  input  1  clock; all logic is rising-edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  single-cycle pulse; latches the layer config and begins a layer.
REQ-006 out_channel  input  16  output channel count C, legal range 1..MAX_CH.
REQ-007 out_pixels  input  32  output pixel count P per layer, legal range ≥1.
REQ-008 param_wr_en  input  1  parameter table write strobe.
REQ-009 param_wr_addr  input  6  channel index to write.
REQ-010 param_wr_data  input  54  {relu[53], shift[52:48] unsigned, mult[47:32] signed, bias[31:0] signed}.
REQ-011 psum_valid  input  1  partial-sum beat valid, driven by the systolic tile.
REQ-012 psum_data  input  256  8 lanes of signed int32; lane i occupies bits [32i+31:32i].
REQ-013 psum_ready  output  1  block can accept a partial-sum beat.
REQ-014 m_valid  output  1  packed output valid.
REQ-015 m_ready  input  1  downstream ready.
REQ-016 m_data  output  64  8 lanes of int8; lane i occupies bits [8i+7:8i].
REQ-017 m_last  output  1  marks the final beat of the layer.
REQ-018 layer_done  output  1  one-cycle pulse when the layer is fully drained.
REQ-019 cfg_err  output  1  sticky flag for an illegal configuration.

Function
REQ-020 States: IDLE, RUN, DRAIN.
- IDLE→RUN on start when C and P are legal.
- RUN→DRAIN when the last beat is accepted.
- DRAIN→IDLE when the pipeline and FIFO are empty, with layer_done pulsed in that cycle.
REQ-021 start with C=0, C>MAX_CH, or P=0 leaves the state at IDLE and sets cfg_err; cfg_err clears on the next legal start.
REQ-022 start outside IDLE is ignored.
REQ-023 Parameter writes take effect only in IDLE; writes in RUN or DRAIN are dropped.
REQ-024 Beat ordering: each pixel spans G=ceil(C/8) beats. Beat g lane i carries channel 8g+i.
REQ-025 The group counter wraps from G-1 to 0 and increments the pixel counter; m_last=1 on the beat g=G-1 of pixel P-1.
REQ-026 Beat acceptance: a beat is accepted on psum_valid && psum_ready; psum_ready=0 outside RUN.
REQ-027 Flow control: in RUN, psum_ready=1 iff (fifo_count + beats in flight) < FIFO_DEPTH. No beat is ever dropped.
REQ-028 Stage 1: s1 = psum + bias, 33-bit signed, no wrap.
REQ-029 Stage 2: s2 = s1 × mult, 49-bit signed.
REQ-030 Stage 3: for shift>0, s3 = (s2 + 2^(shift-1)) >>> shift (arithmetic shift, round-half-up); for shift=0, s3 = s2.
- Saturate s3 to [-128,127].
- If relu=1, clamp negative results to 0.
REQ-031 Padding lanes (channel ≥ C) output 0x00 regardless of table contents.
REQ-032 Latency: an accepted beat is written to the FIFO exactly 3 cycles later; it is visible on m_valid the following cycle if the FIFO was empty.
REQ-033 m_data, m_last: held stable while m_valid && !m_ready.
REQ-034 FIFO: simultaneous write and read at full or empty is legal and leaves the count unchanged. A write to a full FIFO never occurs, by REQ-027.

Reset
REQ-035 rst forces:
- state=IDLE
- psum_ready=0, m_valid=0, m_last=0, layer_done=0, cfg_err=0
- FIFO and counters cleared
- pipeline valids cleared
REQ-036 Parameter table contents are not reset.
REQ-037 rst asserted mid-layer aborts the layer with no further output beats and no layer_done.

Verification
REQ-038 Identity and saturation: C=8, P=1, all channels bias=0 mult=1 shift=0 relu=0; lanes = {100, 200, -300, 0, 127, -128, 5, -5} → m_data lanes {0x64, 0x7F, 0x80, 0x00, 0x7F, 0x80, 0x05, 0xFB}, m_last=1, then layer_done.
REQ-039 Rounding and ReLU: mult=3, shift=2, bias=0.
- psum=5 → 0x04; psum=-5 → 0xFC (-4).
- With relu=1, psum=-5 → 0x00.
REQ-040 Bias: bias=-10, mult=1, shift=0, psum=4 → 0xFA.
REQ-041 Padding and last: C=35, P=2 → 10 output beats; beats 5 and 10 have lanes 3..7 = 0x00; m_last only on beat 10; exactly one layer_done.
REQ-042 Backpressure: continuous psum_valid with m_ready held low for 20 cycles.
- psum_ready deasserts once 8 beats are outstanding.
- After release, all beats emerge in order with none lost or duplicated.
REQ-043 Illegal config and reset:
- start with C=0 → cfg_err=1 and state stays IDLE.
- rst mid-layer → m_valid=0 next cycle.
- A fresh legal start afterwards completes correctly.
